// File: rtl/uart_tx_drain.sv
// Drains bytes from an upstream FIFO and serialises them as 8N1 UART frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] fifoData,
  input  logic       fifoEmpty,
  output logic       fifoRead,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                baud_end_c;
  logic                timed_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    baud_end_c = (baud_q == BAUD_MAX);
    timed_c    = 1'b0;

    unique case (state_q)
      S_IDLE:  if (!fifoEmpty) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        shift_d = fifoData;
        state_d = S_START;
      end
      S_START: begin
        timed_c = 1'b1;
        if (baud_end_c) state_d = S_DATA;
      end
      S_DATA: begin
        timed_c = 1'b1;
        if (baud_end_c) begin
          // 3-bit index wraps 7->0 on its own as the last data bit retires
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        timed_c = 1'b1;
        if (baud_end_c) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        timed_c = 1'b1;
        if (baud_end_c) state_d = fifoEmpty ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state change and at each bit boundary
    if (timed_c && (state_d == state_q) && !baud_end_c) baud_d = baud_q + BAUD_W'(1);
    else                                                baud_d = '0;

    // Outputs are computed from the next state so the line is registered
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    rd_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  assign tx       = tx_q;
  assign fifoRead = rd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model, line monitor and frame scoreboard at CLKS_PER_BIT=4.
module tb_uart_tx_drain;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;
  localparam logic [10:0] MASK = 11'((32'd1 << NB) - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] fifoData = 8'h00;
  logic       fifoEmpty = 1'b1;
  logic       fifoRead, tx, busy;

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(clk), .RST_N(rst_n), .fifoData(fifoData), .fifoEmpty(fifoEmpty),
    .fifoRead(fifoRead), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame in line order: start, d0..d7, [even parity], stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    f[9] = 1'((ones % 2));
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  logic [7:0]  fifo_q[$];
  logic [10:0] exp_q[$];
  bit          noise = 1'b0;
  int          hold = 0;
  int          underflow = 0;
  int          rd_cnt = 0;
  int          rd_long = 0;
  bit          rd_prev = 1'b0;
  int          busy_cnt = 0;

  int          cyc = 0;
  bit          in_frame = 1'b0;
  bit          prev_tx = 1'b1;
  int          fcyc = 0;
  int          mb;
  logic [10:0] cap = '1;
  bit          glitch = 1'b0;
  logic [10:0] last_cap = '1;
  int          frame_cnt = 0;
  int          start_cyc = 0;
  int          prev_end = -1000;
  int          last_gap = 0;
  logic [10:0] e;

  // FIFO model plus line monitor, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (fifoRead === 1'b1) begin
      rd_cnt++;
      if (rd_prev) rd_long++;
      if (fifo_q.size() == 0) underflow++;
      else begin
        fifoData = fifo_q.pop_front();
        hold = 1;
      end
    end else if (hold > 0) hold--;
    else if (noise) fifoData = 8'($urandom);
    rd_prev = (fifoRead === 1'b1);
    fifoEmpty = (fifo_q.size() == 0);
    if (busy === 1'b1) busy_cnt++;

    if (!rst_n) begin
      in_frame = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!in_frame && prev_tx && tx === 1'b0) begin
        in_frame = 1'b1;
        fcyc = 0;
        glitch = 1'b0;
        start_cyc = cyc;
        last_gap = start_cyc - prev_end - 1;
      end
      if (in_frame) begin
        mb = fcyc / int'(CPB);
        if (fcyc % int'(CPB) == 0) cap[mb] = tx;
        else if (tx !== cap[mb]) glitch = 1'b1;
        fcyc++;
        if (fcyc == FRAME) begin
          in_frame = 1'b0;
          prev_end = cyc;
          last_cap = cap;
          frame_cnt++;
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("frame_bits", cap & MASK, e & MASK);
            check("bit_width", glitch, 0);
          end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(model_frame(d));
  endtask

  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while (frame_cnt < target && t < 3000) begin
      tick(1);
      t++;
    end
    if (frame_cnt < target) check({name, "_timeout"}, frame_cnt, target);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || fifo_q.size() != 0) && t < 3000) begin
      tick(1);
      t++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t tbl[9];
  int   f0, r0, b0, rel, bad, t;
  logic [7:0] rb;

  initial begin
    tbl[0] = '{8'h55, 10'h2AA, 1'b0};
    tbl[1] = '{8'hA3, 10'h346, 1'b0};
    tbl[2] = '{8'h0F, 10'h21E, 1'b0};
    tbl[3] = '{8'h07, 10'h20E, 1'b1};
    tbl[4] = '{8'h03, 10'h206, 1'b0};
    tbl[5] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[6] = '{8'h00, 10'h200, 1'b0};
    tbl[7] = '{8'h80, 10'h300, 1'b1};
    tbl[8] = '{8'h3C, 10'h278, 1'b0};

    #1 rst_n = 1'b0;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_fifoRead", fifoRead, 0);
    check("rst_busy", busy, 0);

    // Byte queued during reset: first start bit after IDLE, REQ, WAIT
    push(8'h55);
    tick(2);
    b0 = busy_cnt;
    r0 = rd_cnt;
    rst_n = 1'b1;
    rel = cyc;
    wait_frames(1, "first");
    check("first_start_latency", start_cyc - rel, 4);
    wait_idle();
    check("first_busy_cycles", busy_cnt - b0, FRAME + 2);
    check("first_reads", rd_cnt - r0, 1);

    foreach (tbl[i]) begin
      f0 = frame_cnt;
      b0 = busy_cnt;
      r0 = rd_cnt;
      push(tbl[i].data);
      wait_frames(f0 + 1, "tbl");
      wait_idle();
      check("tbl_line", {last_cap[NB-1], last_cap[8:0]}, tbl[i].line);
`ifdef UART_TX_PARITY_EN
      check("tbl_parity", last_cap[9], tbl[i].par);
`endif
      check("tbl_busy_cycles", busy_cnt - b0, FRAME + 2);
      check("tbl_reads", rd_cnt - r0, 1);
    end

    // Back-to-back bytes: two idle-high cycles between frames
    f0 = frame_cnt;
    r0 = rd_cnt;
    push(8'hA3);
    push(8'h0F);
    wait_frames(f0 + 2, "b2b");
    check("b2b_gap", last_gap, 2);
    check("b2b_second", {last_cap[NB-1], last_cap[8:0]}, 10'h21E);
    wait_idle();
    check("b2b_reads", rd_cnt - r0, 2);

    // Empty FIFO for 100 cycles
    r0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (fifoRead !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_reads", rd_cnt - r0, 0);

    // fifoData scrambled outside the WAIT cycle
    f0 = frame_cnt;
    noise = 1'b1;
    push(8'h3C);
    wait_frames(f0 + 1, "noise");
    noise = 1'b0;
    check("noise_line", {last_cap[NB-1], last_cap[8:0]}, 10'h278);
    wait_idle();

    // Reset during data bit 3 of 0xFF aborts the frame
    f0 = frame_cnt;
    push(8'hFF);
    t = 0;
    while (!(in_frame && fcyc >= int'(CPB) * 4 + 1) && t < 500) begin
      tick(1);
      t++;
    end
    check("abort_reached_bit3", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx_async", tx, 1);
    check("abort_busy_async", busy, 0);
    check("abort_fifoRead", fifoRead, 0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    r0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_no_resend_frames", frame_cnt, f0);
    check("abort_no_resend_reads", rd_cnt - r0, 0);
    check("abort_line_idle", bad, 0);

    // Random traffic, frames checked by the scoreboard
    f0 = frame_cnt;
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      push(rb);
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      tick($urandom_range(0, 60));
    end
    wait_frames(f0 + 1, "rand");
    t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < 5000) begin
      tick(1);
      t++;
    end
    check("rand_all_sent", exp_q.size(), 0);

    check("fifo_underflow", underflow, 0);
    check("fifoRead_single_cycle", rd_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
